data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between two requesters: port 0 (core load/store stage) and port 1 (program loader / debug port).
- Drives the memory's rw_addr/w_data/w_en/funct3 inputs and samples its combinational r_data.
- Round-robin arbitration, optional multi-cycle bus lock with a bounded hold counter, and a registered one-cycle read response.

Parameters:
- ADDR_W, 32, address width on both requesters and on the memory side.
- MAX_LOCK, 8, maximum consecutive granted cycles a locked owner may keep; range 1..255.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  access request from port 0 / 1.
- lock0 / lock1  in  1  keep ownership after the current beat (read-modify-write, burst).
- addr0 / addr1  in  ADDR_W  byte address.
- wdata0 / wdata1  in  32  store data, LSB-aligned.
- we0 / we1  in  1  1 = store, 0 = load.
- funct3_0 / funct3_1  in  3  RISC-V load/store funct3 (size in [1:0], unsigned flag in [2]).
- gnt0 / gnt1  out  1  beat accepted this cycle (combinational).
- rvalid0 / rvalid1  out  1  load data valid, one cycle after the granting cycle.
- rdata0 / rdata1  out  32  registered load data.
- err0 / err1  out  1  error response, same timing as rvalid (see Optional Feature).
- mem_rw_addr  out  ADDR_W  to memory rw_addr.
- mem_w_data  out  32  to memory w_data.
- mem_w_en  out  1  to memory w_en.
- mem_funct3  out  3  to memory funct3.
- mem_r_data  in  32  from memory r_data, combinational.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), lock_cnt=0.
  - rvalid*, rdata*, err* all 0.
  - gnt*=0 and mem_w_en=0 while reset_n=0.
- States:
  - IDLE: no owner.
  - OWN0: port 0 holds the lock.
  - OWN1: port 1 holds the lock.
- IDLE arbitration, same cycle:
  - Only one req asserted: that port is granted.
  - Both asserted: the port other than last_grant is granted.
  - On each grant, last_grant is updated to the granted port.
- Granted beat:
  - gnt=1 for the winner only.
  - mem_* outputs are driven from the winner's addr/wdata/we/funct3; mem_w_en = we of the winner.
  - A store commits in the memory at the end of the granting cycle.
  - For a load, mem_r_data is captured into rdata of the winner and rvalid is asserted for exactly one cycle after.
  - The loser sees gnt=0 and must hold its request stable.
- Non-granted cycles: mem_w_en=0; mem_rw_addr, mem_w_data and mem_funct3 hold the port-0 values (don't-care, but deterministic).
- Lock entry and hold:
  - Granted beat with lock=1 in IDLE: go to OWNx, lock_cnt=1.
  - In OWNx, only port x is considered. Its req is granted every cycle it is asserted; the other port waits regardless of its req.
  - Each granted beat in OWNx increments lock_cnt.
- Lock exit:
  - Go to IDLE when a granted beat has lock=0, when req=0 and lock=0, or when lock_cnt reaches MAX_LOCK.
  - On the MAX_LOCK exit, the other port wins the next cycle if it is requesting.
  - OWNx with req=0 but lock=1: stay, no grant, lock_cnt unchanged.
- Back-to-back beats: one beat per cycle, zero bubbles. rvalid of beat N coincides with the gnt of beat N+1.
- Response accept: rvalid/err are not back-pressured; requesters must accept them.
- Reset mid-lock: returns to IDLE immediately. A pending rvalid is dropped, and no write may occur during reset.
- funct3 size 2'b11 is passed through unmodified unless the Optional Feature is enabled.

Optional Feature:
- Macro: DATA_MEM_ARB_ALIGN_CHECK_EN.
- Defined, a granted beat is rejected if it is misaligned or has an illegal size. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0; illegal size means funct3[1:0]=2'b11.
  - On rejection: gnt=1, mem_w_en=0, and err=1 one cycle later with rvalid=0 and rdata=0.
  - A rejected beat counts toward lock_cnt and ends the lock.
- Undefined: no checking; err* are tied to 0 and all beats go to memory.

Decomposition:
- Shared package data_mem_pkg:
  - state encoding IDLE=2'd0, OWN0=2'd1, OWN1=2'd2;
  - funct3 size codes SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - MEM_DEPTH constant (16385 bytes).
- One natural sub-module, data_mem_rr_pick: two-input round-robin picker taking req0/req1/last_grant and returning the grant vector, combinational.
- The FSM, lock counter and response registers stay in the top.

Test Plan:
- Single store/load on port 0: sw 0xDEADBEEF @0x100, then lw @0x100 → gnt0 in the request cycle, rvalid0 one cycle later with rdata0=0xDEADBEEF.
- Simultaneous req0/req1 loads after reset → cycle 0 gnt0, cycle 1 gnt1 (port 1 held its request). The pair repeated twice alternates 0,1,0,1.
- Lock RMW on port 1: lb @0x20 then sb 0x5A with lock1=1 while req0 is held → port 0 is never granted until the lock drops; the final byte is 0x5A; then gnt0 follows.
- MAX_LOCK=4 with lock0 held for 10 cycles and req1 asserted → exactly 4 gnt0, then gnt1 on the next cycle.
- reset_n pulsed low during OWN0 with a pending load → rvalid0=0 and state IDLE. A store presented during reset leaves memory unchanged.
- DATA_MEM_ARB_ALIGN_CHECK_EN: sh @0x101 → gnt=1, memory unchanged, err=1 next cycle. The same access without the macro writes bytes 0x101/0x102.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: FSM states, funct3 size
// codes, memory depth, response record and the alignment helper.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int MEM_DEPTH = 16385;

    // Registered per-port load response.
    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
    } arb_rsp_t;

    // True when the access is misaligned for its size or uses the reserved size.
    function automatic logic bad_access(input logic [1:0] addr_lo, input logic [2:0] funct3);
        logic bad;
        case (funct3[1:0])
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_rr_pick.sv
// Two-input round-robin picker: on a tie the port that did not win last time
// is granted. Purely combinational.
module data_mem_rr_pick (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // Tie goes to the port other than last_grant; a lone request always wins.
    always_comb begin
        gnt = {req1, req0};
        if (req0 && req1)
            gnt = last_grant ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory. Round-robin in
// IDLE, optional bus lock bounded by MAX_LOCK, registered one-cycle load
// response. Optional alignment checking under DATA_MEM_ARB_ALIGN_CHECK_EN.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic              we0,
    input  logic              we1,
    input  logic [2:0]        funct3_0,
    input  logic [2:0]        funct3_1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_rw_addr,
    output logic [31:0]       mem_w_data,
    output logic              mem_w_en,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_r_data
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    arb_state_e state;
    logic       last_grant;
    logic [7:0] lock_cnt;
    logic [7:0] cnt_inc;
    logic [1:0] pick_req, pick_gnt, gnt;
    logic       any_gnt, sel1, beat_we, beat_lock, own_lock;
    logic       reject, is_load;
    arb_rsp_t   rsp0, rsp1;

    // A lock owner masks out the other port entirely.
    always_comb begin
        case (state)
            IDLE:    pick_req = {req1, req0};
            OWN0:    pick_req = {1'b0, req0};
            OWN1:    pick_req = {req1, 1'b0};
            default: pick_req = 2'b00;
        endcase
    end

    data_mem_rr_pick u_pick (
        .req0       (pick_req[0]),
        .req1       (pick_req[1]),
        .last_grant (last_grant),
        .gnt        (pick_gnt)
    );

    // No grant, and therefore no write, while reset is held.
    assign gnt     = reset_n ? pick_gnt : 2'b00;
    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign any_gnt = |gnt;
    assign sel1    = gnt[1];

    // Port 0 drives the bus whenever port 1 is not the winner.
    assign mem_rw_addr = sel1 ? addr1    : addr0;
    assign mem_w_data  = sel1 ? wdata1   : wdata0;
    assign mem_funct3  = sel1 ? funct3_1 : funct3_0;
    assign beat_we     = sel1 ? we1      : we0;
    assign beat_lock   = sel1 ? lock1    : lock0;
    assign own_lock    = (state == OWN1) ? lock1 : lock0;
    assign cnt_inc     = lock_cnt + 8'd1;

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
    assign reject = any_gnt & bad_access(mem_rw_addr[1:0], mem_funct3);
`else
    assign reject = 1'b0;
`endif

    assign mem_w_en = any_gnt & beat_we & ~reject;
    assign is_load  = any_gnt & ~beat_we & ~reject;

    // Ownership FSM with bounded lock counter and round-robin history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lock_cnt   <= 8'd0;
        end else begin
            if (any_gnt)
                last_grant <= sel1;
            case (state)
                IDLE: begin
                    // With MAX_LOCK=1 the first beat already exhausts the lock.
                    if (any_gnt && beat_lock && !reject && (MAX_LOCK > 1)) begin
                        state    <= sel1 ? OWN1 : OWN0;
                        lock_cnt <= 8'd1;
                    end
                end
                OWN0, OWN1: begin
                    if (any_gnt) begin
                        if (!beat_lock || reject || (cnt_inc == MAX_CNT)) begin
                            state    <= IDLE;
                            lock_cnt <= 8'd0;
                        end else begin
                            lock_cnt <= cnt_inc;
                        end
                    end else if (!own_lock) begin
                        state    <= IDLE;
                        lock_cnt <= 8'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Load responses: capture memory data for the winner, pulse rvalid once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp0 <= '0;
            rsp1 <= '0;
        end else begin
            rsp0.rvalid <= gnt[0] & is_load;
            rsp1.rvalid <= gnt[1] & is_load;
            if (gnt[0] && is_load)
                rsp0.rdata <= mem_r_data;
            else if (gnt[0] && reject)
                rsp0.rdata <= 32'd0;
            if (gnt[1] && is_load)
                rsp1.rdata <= mem_r_data;
            else if (gnt[1] && reject)
                rsp1.rdata <= 32'd0;
        end
    end

    assign rvalid0 = rsp0.rvalid;
    assign rvalid1 = rsp1.rvalid;
    assign rdata0  = rsp0.rdata;
    assign rdata1  = rsp1.rdata;

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
    logic err0_q, err1_q;

    // Error response for rejected beats, same timing as rvalid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            err0_q <= gnt[0] & reject;
            err1_q <= gnt[1] & reject;
        end
    end

    assign err0 = err0_q;
    assign err1 = err1_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-array memory model.
module tb_data_mem_arbiter;
    import data_mem_pkg::*;

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [2:0]  funct3_0, funct3_1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_rw_addr, mem_w_data, mem_r_data;
    logic        mem_w_en;
    logic [2:0]  mem_funct3;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    data_mem_arbiter #(.ADDR_W(32), .MAX_LOCK(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .funct3_0(funct3_0), .funct3_1(funct3_1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_rw_addr(mem_rw_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
        .mem_funct3(mem_funct3), .mem_r_data(mem_r_data)
    );

    // Memory model: little-endian bytes, combinational RISC-V style read.
    logic [7:0] mem [MEM_DEPTH];

    function automatic int unsigned ix(input logic [31:0] a);
        return a % MEM_DEPTH;
    endfunction

    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[ix(mem_rw_addr)];
        b1 = mem[ix(mem_rw_addr + 32'd1)];
        b2 = mem[ix(mem_rw_addr + 32'd2)];
        b3 = mem[ix(mem_rw_addr + 32'd3)];
        case (mem_funct3[1:0])
            2'b00:   mem_r_data = mem_funct3[2] ? {24'd0, b0} : {{24{b0[7]}}, b0};
            2'b01:   mem_r_data = mem_funct3[2] ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: mem_r_data = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clock) begin
        if (mem_w_en) begin
            mem[ix(mem_rw_addr)] <= mem_w_data[7:0];
            if (mem_funct3[1:0] != 2'b00)
                mem[ix(mem_rw_addr + 32'd1)] <= mem_w_data[15:8];
            if (mem_funct3[1] == 1'b1) begin
                mem[ix(mem_rw_addr + 32'd2)] <= mem_w_data[23:16];
                mem[ix(mem_rw_addr + 32'd3)] <= mem_w_data[31:24];
            end
        end
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {mem[ix(a + 32'd3)], mem[ix(a + 32'd2)], mem[ix(a + 32'd1)], mem[ix(a)]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic p0(input logic r, input logic l, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d; funct3_0 = f;
    endtask

    task automatic p1(input logic r, input logic l, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d; funct3_1 = f;
    endtask

    task automatic drop();
        p0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        p1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    endtask

    task automatic do_reset();
        drop();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drop();
        repeat (2) @(posedge clock);
        #1;

        // Reset: a store presented during reset gets no grant and no write.
        p0(1'b1, 1'b0, 1'b1, 32'h100, 32'h1111_1111, 3'b010);
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_wen", mem_w_en, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_err0", err0, 0);
        cyc();
        drop();
        reset_n = 1'b1;

        // Single store then load on port 0.
        p0(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010);
        #1;
        chk("sw_gnt0", gnt0, 1);
        chk("sw_gnt1", gnt1, 0);
        chk("sw_wen", mem_w_en, 1);
        chk("sw_addr", mem_rw_addr, 32'h100);
        cyc();
        chk("sw_no_rvalid", rvalid0, 0);
        p0(1'b1, 1'b0, 1'b0, 32'h100, 32'd0, 3'b010);
        #1;
        chk("lw_gnt0", gnt0, 1);
        chk("lw_wen", mem_w_en, 0);
        cyc();
        chk("lw_rvalid0", rvalid0, 1);
        chk("lw_rdata0", rdata0, 32'hDEAD_BEEF);
        p0(1'b1, 1'b0, 1'b1, 32'h104, 32'h4433_2211, 3'b010);
        cyc();
        chk("rvalid_pulse", rvalid0, 0);
        p0(1'b1, 1'b0, 1'b1, 32'h20, 32'h0000_0081, 3'b000);
        cyc();
        drop();
        addr0 = 32'h55;
        #1;
        chk("idle_addr", mem_rw_addr, 32'h55);
        chk("idle_wen", mem_w_en, 0);
        chk("idle_gnt0", gnt0, 0);
        cyc();

        // Simultaneous loads after reset alternate 0,1,0,1, zero bubbles.
        do_reset();
        p0(1'b1, 1'b0, 1'b0, 32'h100, 32'd0, 3'b010);
        p1(1'b1, 1'b0, 1'b0, 32'h104, 32'd0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2 == 0));
            chk($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2 == 1));
            if (i % 2 == 1) begin
                chk($sformatf("rr_rvalid0_%0d", i), rvalid0, 1);
                chk($sformatf("rr_rdata0_%0d", i), rdata0, 32'hDEAD_BEEF);
            end else if (i > 0) begin
                chk($sformatf("rr_rvalid1_%0d", i), rvalid1, 1);
                chk($sformatf("rr_rdata1_%0d", i), rdata1, 32'h4433_2211);
            end
            cyc();
        end
        chk("rr_rvalid1_last", rvalid1, 1);
        drop();

        // Locked read-modify-write on port 1 while port 0 waits.
        p1(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 3'b000);
        #1;
        chk("rmw_lb_gnt1", gnt1, 1);
        cyc();
        p1(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 3'b000);
        p0(1'b1, 1'b0, 1'b0, 32'h100, 32'd0, 3'b010);
        #1;
        chk("rmw_hold_gnt0", gnt0, 0);
        chk("rmw_hold_gnt1", gnt1, 0);
        chk("rmw_lb_rvalid1", rvalid1, 1);
        chk("rmw_lb_rdata1", rdata1, 32'hFFFF_FF81);
        cyc();
        p1(1'b1, 1'b0, 1'b1, 32'h20, 32'h0000_005A, 3'b000);
        #1;
        chk("rmw_sb_gnt1", gnt1, 1);
        chk("rmw_sb_gnt0", gnt0, 0);
        cyc();
        p1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        #1;
        chk("rmw_after_gnt0", gnt0, 1);
        chk("rmw_byte", {24'd0, mem[32'h20]}, 32'h5A);
        cyc();
        drop();

        // Lock bounded at MAX_LOCK=4, then the waiting port wins.
        do_reset();
        p0(1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 3'b010);
        p1(1'b1, 1'b0, 1'b0, 32'h104, 32'd0, 3'b010);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("ml_gnt0_%0d", i), gnt0, (i != 4));
            chk($sformatf("ml_gnt1_%0d", i), gnt1, (i == 4));
            cyc();
            if (i == 4)
                p1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        end

        // Reset during OWN0 with a load in flight; store during reset ignored.
        #1;
        chk("mr_gnt0", gnt0, 1);
        #2;
        reset_n = 1'b0;
        p0(1'b1, 1'b1, 1'b1, 32'h100, 32'h1234_5678, 3'b010);
        #1;
        chk("mr_gnt0_rst", gnt0, 0);
        chk("mr_wen_rst", mem_w_en, 0);
        cyc();
        chk("mr_rvalid0", rvalid0, 0);
        cyc();
        chk("mr_mem", rd_word(32'h100), 32'hDEAD_BEEF);
        reset_n = 1'b1;
        drop();
        p1(1'b1, 1'b0, 1'b0, 32'h104, 32'd0, 3'b010);
        #1;
        chk("mr_idle_gnt1", gnt1, 1);
        cyc();
        drop();

        // Misaligned halfword store at 0x101.
        p0(1'b1, 1'b0, 1'b1, 32'h101, 32'h0000_1234, 3'b001);
        #1;
        chk("sh_gnt0", gnt0, 1);
        chk("sh_wen", mem_w_en, ALN ? 32'd0 : 32'd1);
        cyc();
        chk("sh_err0", err0, ALN ? 32'd1 : 32'd0);
        chk("sh_rvalid0", rvalid0, 0);
        chk("sh_mem", rd_word(32'h100), ALN ? 32'hDEAD_BEEF : 32'hDE12_34EF);
        p0(1'b1, 1'b0, 1'b0, 32'h100, 32'd0, 3'b010);
        cyc();
        chk("sh_lw_rdata0", rdata0, ALN ? 32'hDEAD_BEEF : 32'hDE12_34EF);

        // Reserved size 2'b11 passes through unless checking is enabled.
        p0(1'b1, 1'b0, 1'b0, 32'h100, 32'd0, 3'b011);
        #1;
        chk("sz3_f3", {29'd0, mem_funct3}, 32'd3);
        chk("sz3_gnt0", gnt0, 1);
        cyc();
        chk("sz3_err0", err0, ALN ? 32'd1 : 32'd0);
        chk("sz3_rvalid0", rvalid0, ALN ? 32'd0 : 32'd1);
        drop();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
